// File: rtl/memory_mod.sv
// Memory stage of the RV32 pipeline: word loads/stores against an internal data RAM
// with optional access latency, feeding the M/W pipeline register and the write-back mux.
module memory_mod #(
  parameter int DEPTH   = 64,
  parameter int MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemwriteM,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCplus4M,
  input  logic [4:0]  RdM,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ALUresultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCplus4W,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          access;
  logic          complete;
  logic [AW-1:0] idx;
  logic [31:0]   mem_q [DEPTH];

  logic        reg_write_q, result_src_q;
  logic [31:0] alu_result_q, read_data_q, pc_plus4_q;
  logic [4:0]  rd_q;

  // Low two bits and everything above the RAM size are dropped: aligned, wrapping access.
  assign idx    = ALUresultM[AW+1:2];
  assign access = MemwriteM | (ResultSrcM & RegWriteM);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    StallM   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && (LAT != 4'd0)) begin
          state_d = WAIT;
          cnt_d   = LAT - 4'd1;
          StallM  = 1'b1;
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d  = cnt_q - 4'd1;
          StallM = 1'b1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the RAM array has no reset; clearing it would turn block RAM into a flop array.
  always_ff @(posedge clk) begin
    if (complete && MemwriteM) mem_q[idx] <= WriteDataM;
  end

  // A stalled cycle inserts a bubble: only the control bits clear, the data fields hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      alu_result_q <= 32'd0;
      read_data_q  <= 32'd0;
      pc_plus4_q   <= 32'd0;
      rd_q         <= 5'd0;
    end else if (complete) begin
      reg_write_q  <= RegWriteM;
      result_src_q <= ResultSrcM;
      alu_result_q <= ALUresultM;
      read_data_q  <= mem_q[idx];
      pc_plus4_q   <= PCplus4M;
      rd_q         <= RdM;
    end else begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
    end
  end

  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign ALUresultW = alu_result_q;
  assign ReadDataW  = read_data_q;
  assign PCplus4W   = pc_plus4_q;
  assign RdW        = rd_q;
  assign ResultW    = result_src_q ? read_data_q : alu_result_q;

endmodule

// File: tb/tb_memory_mod.sv
// Self-checking bench for memory_mod: three instances (latency 0, 3, 2) share one input
// bus; each phase resets, then drives directed and random traffic at one instance.
module tb_memory_mod;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write = 1'b0, result_src = 1'b0, mem_write = 1'b0;
  logic [31:0] alu_result = '0, write_data = '0, pc_plus4 = '0;
  logic [4:0]  rd = '0;

  logic        stall_o [3];
  logic        rw_o    [3];
  logic        rs_o    [3];
  logic [31:0] alu_o   [3];
  logic [31:0] rdata_o [3];
  logic [31:0] pc4_o   [3];
  logic [31:0] res_o   [3];
  logic [4:0]  rd_o    [3];

  int tests  = 0;
  int failed = 0;

  // Reference model: word array indexed by byte address / 4 modulo DEPTH.
  logic [31:0] ref_mem [DEPTH];
  int          written [$];

  always #5 clk = ~clk;

  memory_mod #(.DEPTH(DEPTH), .MEM_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .RegWriteM(reg_write), .ResultSrcM(result_src), .MemwriteM(mem_write),
    .ALUresultM(alu_result), .WriteDataM(write_data), .PCplus4M(pc_plus4), .RdM(rd),
    .StallM(stall_o[0]), .RegWriteW(rw_o[0]), .ResultSrcW(rs_o[0]), .ALUresultW(alu_o[0]),
    .ReadDataW(rdata_o[0]), .PCplus4W(pc4_o[0]), .RdW(rd_o[0]), .ResultW(res_o[0]));

  memory_mod #(.DEPTH(DEPTH), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .RegWriteM(reg_write), .ResultSrcM(result_src), .MemwriteM(mem_write),
    .ALUresultM(alu_result), .WriteDataM(write_data), .PCplus4M(pc_plus4), .RdM(rd),
    .StallM(stall_o[1]), .RegWriteW(rw_o[1]), .ResultSrcW(rs_o[1]), .ALUresultW(alu_o[1]),
    .ReadDataW(rdata_o[1]), .PCplus4W(pc4_o[1]), .RdW(rd_o[1]), .ResultW(res_o[1]));

  memory_mod #(.DEPTH(DEPTH), .MEM_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .RegWriteM(reg_write), .ResultSrcM(result_src), .MemwriteM(mem_write),
    .ALUresultM(alu_result), .WriteDataM(write_data), .PCplus4M(pc_plus4), .RdM(rd),
    .StallM(stall_o[2]), .RegWriteW(rw_o[2]), .ResultSrcW(rs_o[2]), .ALUresultW(alu_o[2]),
    .ReadDataW(rdata_o[2]), .PCplus4W(pc4_o[2]), .RdW(rd_o[2]), .ResultW(res_o[2]));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  task automatic check_zero(input int d, input string tag);
    check({tag, " stall"}, 32'(stall_o[d]), 32'd0);
    check({tag, " rw"},    32'(rw_o[d]),    32'd0);
    check({tag, " rs"},    32'(rs_o[d]),    32'd0);
    check({tag, " alu"},   alu_o[d],        32'd0);
    check({tag, " rdata"}, rdata_o[d],      32'd0);
    check({tag, " pc4"},   pc4_o[d],        32'd0);
    check({tag, " rd"},    32'(rd_o[d]),    32'd0);
    check({tag, " res"},   res_o[d],        32'd0);
  endtask

  task automatic drive(input bit we, input bit rs, input bit rw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] r);
    mem_write  = we;
    result_src = rs;
    reg_write  = rw;
    alu_result = alu;
    write_data = wd;
    rd         = r;
    pc_plus4   = $urandom;
  endtask

  // Called #1 after a rising edge; presents one instruction, walks it through the
  // stall cycles and checks the W register against the model. Returns #1 after its last edge.
  task automatic issue(input int d, input bit we, input bit rs, input bit rw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] r);
    int          lat    = lat_of(d);
    bit          access = we || (rs && rw);
    bit          is_ld  = rs && rw;
    int          widx   = int'((alu / 4) % DEPTH);
    logic [31:0] exp_ld = ref_mem[widx];
    logic [31:0] pc4;
    drive(we, rs, rw, alu, wd, r);
    pc4 = pc_plus4;
    #1;
    if (access) begin
      for (int k = 0; k < lat; k++) begin
        check($sformatf("stall[%0d] cyc%0d", d, k), 32'(stall_o[d]), 32'd1);
        @(posedge clk); #1;
        check($sformatf("bubble rw[%0d]", d), 32'(rw_o[d]), 32'd0);
        check($sformatf("bubble rs[%0d]", d), 32'(rs_o[d]), 32'd0);
      end
    end
    check($sformatf("stall end[%0d]", d), 32'(stall_o[d]), 32'd0);
    @(posedge clk); #1;
    check($sformatf("rw[%0d]", d),  32'(rw_o[d]), 32'(rw));
    check($sformatf("rs[%0d]", d),  32'(rs_o[d]), 32'(rs));
    check($sformatf("rd[%0d]", d),  32'(rd_o[d]), 32'(r));
    check($sformatf("alu[%0d]", d), alu_o[d], alu);
    check($sformatf("pc4[%0d]", d), pc4_o[d], pc4);
    if (is_ld) begin
      check($sformatf("ld data[%0d] @%h", d, alu), rdata_o[d], exp_ld);
      check($sformatf("ld res[%0d] @%h", d, alu),  res_o[d],   exp_ld);
    end else if (!rs) begin
      check($sformatf("alu res[%0d]", d), res_o[d], alu);
    end
    if (we) begin
      ref_mem[widx] = wd;
      written.push_back(widx);
    end
  endtask

  task automatic random_traffic(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      int          kind = int'($urandom_range(0, 2));
      int          widx;
      logic [31:0] addr;
      if (kind == 1 && written.size() == 0) kind = 0;
      widx = (kind == 1) ? written[$urandom_range(0, written.size() - 1)]
                         : int'($urandom_range(0, DEPTH - 1));
      addr = ($urandom & ~32'(DEPTH * 4 - 1)) | 32'(widx * 4) | 32'($urandom_range(0, 3));
      case (kind)
        0:       issue(d, 1'b1, 1'b0, 1'b0, addr, $urandom, 5'(($urandom)));
        1:       issue(d, 1'b0, 1'b1, 1'b1, addr, $urandom, 5'(($urandom)));
        default: issue(d, 1'b0, 1'b0, 1'b1, $urandom, $urandom, 5'(($urandom)));
      endcase
    end
  endtask

  task automatic restart();
    written.delete();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state, held from time 0 with pass-through inputs.
    #2;
    for (int d = 0; d < 3; d++) check_zero(d, $sformatf("por[%0d]", d));
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Latency 0: store/load, ignored low bits, address wrap.
    issue(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
    issue(0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd5);
    issue(0, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 5'd6);
    issue(0, 1'b1, 1'b0, 1'b0, 32'(DEPTH * 4 + 'h10), 32'hCAFEF00D, 5'd0);
    issue(0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd9);
    random_traffic(0, 24);

    // Asynchronous mid-cycle reset clears W without a clock edge.
    #3 rst = 1'b0;
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    for (int d = 0; d < 3; d++) check_zero(d, $sformatf("async rst[%0d]", d));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Latency 3: load stalls three cycles, then an ALU op follows one cycle later.
    written.delete();
    issue(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h600DF00D, 5'd0);
    issue(1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd3);
    issue(1, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd4);
    random_traffic(1, 20);

    // Latency 2: reset during the second stall cycle drops the pending store.
    restart();
    issue(2, 1'b1, 1'b0, 1'b0, 32'h20, 32'h11111111, 5'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h20, 32'hA5A5A5A5, 5'd0);
    #1;
    check("drop stall1", 32'(stall_o[2]), 32'd1);
    @(posedge clk); #1;
    check("drop stall2", 32'(stall_o[2]), 32'd1);
    rst = 1'b0;
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    check_zero(2, "drop rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(2, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd7);
    random_traffic(2, 16);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
